// File: rtl/tsp_2opt_sched_if.sv
// Candidate, result and reversal handshakes between the 2-opt sequencer and
// the evaluator / path store. master = sequencer side.
interface tsp_2opt_sched_if #(
  parameter int unsigned IDX_W   = 6,
  parameter int unsigned DELTA_W = 32
);
  logic               cand_valid;
  logic               cand_ready;
  logic [IDX_W-1:0]   cand_i;
  logic [IDX_W-1:0]   cand_j;
  logic               res_valid;
  logic [DELTA_W-1:0] res_delta;
  logic               swap_valid;
  logic               swap_ready;
  logic [IDX_W-1:0]   swap_i;
  logic [IDX_W-1:0]   swap_j;

  modport master (
    output cand_valid, cand_i, cand_j, swap_valid, swap_i, swap_j,
    input  cand_ready, res_valid, res_delta, swap_ready
  );

  modport slave (
    input  cand_valid, cand_i, cand_j, swap_valid, swap_i, swap_j,
    output cand_ready, res_valid, res_delta, swap_ready
  );
endinterface

// File: rtl/tsp_2opt_sched.sv
// First-improvement 2-opt sweep sequencer over an N-city path (path[0] fixed).
// Define TSP_SCHED_STATS_EN to expose sweep_count/swap_count; otherwise both read 0.
module tsp_2opt_sched #(
  parameter int unsigned N          = 64,
  parameter int unsigned IDX_W      = 6,
  parameter int unsigned DELTA_W    = 32,
  parameter int unsigned MAX_SWEEPS = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  output logic                   busy,
  output logic                   done,
  tsp_2opt_sched_if.master       bus,
  output logic [7:0]             sweep_count,
  output logic [15:0]            swap_count
);

  localparam int unsigned IW1 = IDX_W + 1;
  localparam logic [IDX_W:0] LastJ = IW1'(N - 1);
  localparam logic [IDX_W:0] LastI = IW1'(N - 2);
  localparam logic [7:0]     MaxSweeps = 8'(MAX_SWEEPS);

  typedef enum logic [2:0] {StIdle, StIssue, StWait, StSwap, StDone} state_e;

  state_e           state_q;
  logic             busy_q, done_q, cand_valid_q, swap_valid_q, improved_q;
  logic [IDX_W-1:0] i_q, j_q, swap_i_q, swap_j_q;
  logic [7:0]       sweep_q;

  logic [IDX_W:0] i_inc, j_inc, adv_i, adv_j;
  logic [7:0]     sweep_inc;
  logic           res_neg, sweep_end, cap_hit, adv_imp, run_end, do_adv;

  // Next pair in row-major order; one extra bit catches the wrap past N-1.
  always_comb begin
    i_inc = {1'b0, i_q} + 1'b1;
    j_inc = {1'b0, j_q} + 1'b1;
    if (j_inc > LastJ) begin
      adv_i = i_inc;
      adv_j = i_inc + 1'b1;
    end else begin
      adv_i = {1'b0, i_q};
      adv_j = j_inc;
    end
    sweep_end = adv_i > LastI;
    sweep_inc = (sweep_q == 8'hFF) ? sweep_q : sweep_q + 8'd1;
    cap_hit   = sweep_inc == MaxSweeps;
    res_neg   = $signed(bus.res_delta) < 0;
    // A swap handshake counts as an improvement in the same cycle it advances.
    adv_imp   = (state_q == StSwap) || improved_q;
    run_end   = !adv_imp || cap_hit;
    do_adv    = ((state_q == StWait) && bus.res_valid && !res_neg) ||
                ((state_q == StSwap) && bus.swap_ready);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      cand_valid_q <= 1'b0;
      swap_valid_q <= 1'b0;
      improved_q   <= 1'b0;
      i_q          <= '0;
      j_q          <= '0;
      swap_i_q     <= '0;
      swap_j_q     <= '0;
      sweep_q      <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (start) begin
            busy_q       <= 1'b1;
            cand_valid_q <= 1'b1;
            improved_q   <= 1'b0;
            sweep_q      <= '0;
            i_q          <= IDX_W'(1);
            j_q          <= IDX_W'(2);
            state_q      <= StIssue;
          end
        end
        StIssue: begin
          if (bus.cand_ready) begin
            cand_valid_q <= 1'b0;
            state_q      <= StWait;
          end
        end
        StWait: begin
          if (bus.res_valid && res_neg) begin
            swap_i_q     <= i_q;
            swap_j_q     <= j_q;
            swap_valid_q <= 1'b1;
            state_q      <= StSwap;
          end
        end
        StSwap: begin
          if (bus.swap_ready) begin
            swap_valid_q <= 1'b0;
            improved_q   <= 1'b1;
          end
        end
        StDone: begin
          done_q  <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase

      // Shared advance path for non-improving results and completed swaps.
      if (do_adv) begin
        if (sweep_end) begin
          sweep_q <= sweep_inc;
          if (run_end) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= StDone;
          end else begin
            improved_q   <= 1'b0;
            i_q          <= IDX_W'(1);
            j_q          <= IDX_W'(2);
            cand_valid_q <= 1'b1;
            state_q      <= StIssue;
          end
        end else begin
          i_q          <= adv_i[IDX_W-1:0];
          j_q          <= adv_j[IDX_W-1:0];
          cand_valid_q <= 1'b1;
          state_q      <= StIssue;
        end
      end
    end
  end

`ifdef TSP_SCHED_STATS_EN
  logic [15:0] swap_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      swap_cnt_q <= '0;
    end else if ((state_q == StIdle) && start) begin
      swap_cnt_q <= '0;
    end else if ((state_q == StSwap) && bus.swap_ready && (swap_cnt_q != 16'hFFFF)) begin
      swap_cnt_q <= swap_cnt_q + 16'd1;
    end
  end

  assign sweep_count = sweep_q;
  assign swap_count  = swap_cnt_q;
`else
  assign sweep_count = '0;
  assign swap_count  = '0;
`endif

  assign busy           = busy_q;
  assign done           = done_q;
  assign bus.cand_valid = cand_valid_q;
  assign bus.cand_i     = i_q;
  assign bus.cand_j     = j_q;
  assign bus.swap_valid = swap_valid_q;
  assign bus.swap_i     = swap_i_q;
  assign bus.swap_j     = swap_j_q;

endmodule

// File: tb/tb_tsp_2opt_sched.sv
// Directed bench for tsp_2opt_sched: a 5-city instance for ordering/handshake
// scenarios and a 64-city instance with a reduced sweep cap.
module tb_tsp_2opt_sched;

`ifdef TSP_SCHED_STATS_EN
  localparam bit Stats = 1'b1;
`else
  localparam bit Stats = 1'b0;
`endif

  localparam int BigSweeps = 4;
  localparam int BigPairs  = BigSweeps * 1953;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start_s = 1'b0;
  logic start_b = 1'b0;
  logic busy_s, done_s, busy_b, done_b;
  logic [7:0]  sweep_s, sweep_b;
  logic [15:0] swapc_s, swapc_b;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  tsp_2opt_sched_if #(.IDX_W(3), .DELTA_W(32)) bus_s ();
  tsp_2opt_sched_if #(.IDX_W(6), .DELTA_W(32)) bus_b ();

  tsp_2opt_sched #(.N(5), .IDX_W(3), .DELTA_W(32), .MAX_SWEEPS(16)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start_s),
    .busy        (busy_s),
    .done        (done_s),
    .bus         (bus_s),
    .sweep_count (sweep_s),
    .swap_count  (swapc_s)
  );

  tsp_2opt_sched #(.N(64), .IDX_W(6), .DELTA_W(32), .MAX_SWEEPS(BigSweeps)) dut_big (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start_b),
    .busy        (busy_b),
    .done        (done_b),
    .bus         (bus_b),
    .sweep_count (sweep_b),
    .swap_count  (swapc_b)
  );

  // Results of the last drive_small run (pair code = i*8 + j).
  int got_pairs[$];
  int got_swaps[$];
  int done_pulses, overlap_errs, stable_errs, busy_errs, start_wait;
  bit timed_out;

  // Evaluator/path-store responder for the 5-city instance. Leaves the bench at
  // the falling edge inside the done cycle.
  task automatic drive_small(input int mode, input bit stall);
    int pend, pend_delta, sweep_idx, p, last_cand, last_swap;
    bit cv_stalled, sv_stalled, rdy, finished;
    got_pairs.delete();
    got_swaps.delete();
    done_pulses = 0; overlap_errs = 0; stable_errs = 0; busy_errs = 0;
    timed_out = 1'b0; start_wait = 0;
    pend = 0; pend_delta = 0; sweep_idx = -1; last_cand = 0; last_swap = 0;
    cv_stalled = 1'b0; sv_stalled = 1'b0; finished = 1'b0;
    start_s = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      start_wait++;
      if (busy_s) break;
    end
    start_s = 1'b0;
    if (!busy_s) timed_out = 1'b1;
    for (int cyc = 0; cyc < 400 && !timed_out; cyc++) begin
      if (bus_s.cand_valid && bus_s.swap_valid) overlap_errs++;
      if (cv_stalled && (!bus_s.cand_valid ||
          (int'(bus_s.cand_i) * 8 + int'(bus_s.cand_j)) != last_cand)) stable_errs++;
      if (sv_stalled && (!bus_s.swap_valid ||
          (int'(bus_s.swap_i) * 8 + int'(bus_s.swap_j)) != last_swap)) stable_errs++;
      if (pend != 0) begin
        bus_s.res_valid = 1'b1;
        bus_s.res_delta = pend_delta;
        pend = 0;
      end else begin
        bus_s.res_valid = 1'b0;
      end
      if (bus_s.cand_valid) begin
        rdy = stall ? 1'($urandom_range(0, 1)) : 1'b1;
        bus_s.cand_ready = rdy;
        last_cand = int'(bus_s.cand_i) * 8 + int'(bus_s.cand_j);
        cv_stalled = !rdy;
        if (rdy) begin
          p = last_cand;
          got_pairs.push_back(p);
          if (p == 10) sweep_idx++;
          if (mode == 0) pend_delta = 0;
          else pend_delta = (sweep_idx == 0 && p == 20) ? -5 : 3;
          pend = 1;
        end
      end else begin
        bus_s.cand_ready = 1'b0;
        cv_stalled = 1'b0;
      end
      if (bus_s.swap_valid) begin
        rdy = stall ? 1'($urandom_range(0, 1)) : 1'b1;
        bus_s.swap_ready = rdy;
        last_swap = int'(bus_s.swap_i) * 8 + int'(bus_s.swap_j);
        sv_stalled = !rdy;
        if (rdy) got_swaps.push_back(last_swap);
      end else begin
        bus_s.swap_ready = 1'b0;
        sv_stalled = 1'b0;
      end
      if (done_s) begin
        done_pulses++;
        if (busy_s) busy_errs++;
        finished = 1'b1;
        break;
      end
      @(negedge clk);
    end
    bus_s.cand_ready = 1'b0;
    bus_s.swap_ready = 1'b0;
    bus_s.res_valid  = 1'b0;
    if (!finished) timed_out = 1'b1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    start_s = 1'b1;
    @(negedge clk);
    checks++;
    if ({busy_s, done_s, bus_s.cand_valid, bus_s.swap_valid} !== 4'b0) begin
      failures++;
      $display("FAIL reset_flags: got %b expected 0000",
               {busy_s, done_s, bus_s.cand_valid, bus_s.swap_valid});
    end
    checks++;
    if ({bus_s.cand_i, bus_s.cand_j, bus_s.swap_i, bus_s.swap_j} !== 12'h0) begin
      failures++;
      $display("FAIL reset_pairs: got %h expected 0",
               {bus_s.cand_i, bus_s.cand_j, bus_s.swap_i, bus_s.swap_j});
    end
    checks++;
    if ({sweep_s, swapc_s} !== 24'h0) begin
      failures++;
      $display("FAIL reset_counters: got %h expected 0", {sweep_s, swapc_s});
    end
    rst_n = 1'b1;
    @(negedge clk);
    start_s = 1'b0;
    checks++;
    if ({busy_s, bus_s.cand_valid} !== 2'b11) begin
      failures++;
      $display("FAIL start_accept: got busy/cand_valid %b expected 11", {busy_s, bus_s.cand_valid});
    end
    checks++;
    if ({bus_s.cand_i, bus_s.cand_j} !== {3'd1, 3'd2}) begin
      failures++;
      $display("FAIL first_pair: got (%0d,%0d) expected (1,2)", bus_s.cand_i, bus_s.cand_j);
    end
  endtask

  // Starts in ISSUE with cand_ready low.
  task automatic test_unsolicited;
    bus_s.res_valid = 1'b1;
    bus_s.res_delta = -1;
    start_s = 1'b1;
    @(negedge clk);
    bus_s.res_valid = 1'b0;
    start_s = 1'b0;
    checks++;
    if ({bus_s.cand_valid, bus_s.swap_valid, busy_s} !== 3'b101 ||
        {bus_s.cand_i, bus_s.cand_j} !== {3'd1, 3'd2}) begin
      failures++;
      $display("FAIL unsolicited_res: got cv/sv/busy %b pair (%0d,%0d) expected 101 (1,2)",
               {bus_s.cand_valid, bus_s.swap_valid, busy_s}, bus_s.cand_i, bus_s.cand_j);
    end
    bus_s.cand_ready = 1'b1;
    @(negedge clk);
    bus_s.cand_ready = 1'b0;
    start_s = 1'b1;
    checks++;
    if (bus_s.cand_valid !== 1'b0) begin
      failures++;
      $display("FAIL wait_no_cand: got cand_valid %b expected 0", bus_s.cand_valid);
    end
    @(negedge clk);
    start_s = 1'b0;
    checks++;
    if ({bus_s.cand_valid, bus_s.swap_valid, busy_s, done_s} !== 4'b0010) begin
      failures++;
      $display("FAIL start_while_busy: got cv/sv/busy/done %b expected 0010",
               {bus_s.cand_valid, bus_s.swap_valid, busy_s, done_s});
    end
  endtask

  // Starts in WAIT with a result still owed.
  task automatic test_reset_mid_run;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({busy_s, done_s, bus_s.cand_valid, bus_s.swap_valid, sweep_s, swapc_s} !== 28'h0) begin
      failures++;
      $display("FAIL mid_reset: got %h expected 0",
               {busy_s, done_s, bus_s.cand_valid, bus_s.swap_valid, sweep_s, swapc_s});
    end
    @(negedge clk);
    rst_n = 1'b1;
    bus_s.res_valid = 1'b1;
    bus_s.res_delta = -3;
    @(negedge clk);
    bus_s.res_valid = 1'b0;
    checks++;
    if ({busy_s, bus_s.swap_valid} !== 2'b00) begin
      failures++;
      $display("FAIL stale_res_after_reset: got busy/swap_valid %b expected 00",
               {busy_s, bus_s.swap_valid});
    end
    start_s = 1'b1;
    @(negedge clk);
    start_s = 1'b0;
    checks++;
    if (bus_s.cand_valid !== 1'b1 || {bus_s.cand_i, bus_s.cand_j} !== {3'd1, 3'd2}) begin
      failures++;
      $display("FAIL restart_pair: got cv %b (%0d,%0d) expected 1 (1,2)",
               bus_s.cand_valid, bus_s.cand_i, bus_s.cand_j);
    end
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_sweep_order;
    int exp_order[6];
    exp_order = '{10, 11, 12, 19, 20, 28};
    drive_small(0, 1'b0);
    checks++;
    if (timed_out || got_pairs.size() != 6) begin
      failures++;
      $display("FAIL order_count: got %0d pairs (timeout %0d) expected 6",
               got_pairs.size(), timed_out);
    end
    for (int k = 0; k < 6 && k < got_pairs.size(); k++) begin
      checks++;
      if (got_pairs[k] != exp_order[k]) begin
        failures++;
        $display("FAIL order_pair%0d: got (%0d,%0d) expected (%0d,%0d)", k,
                 got_pairs[k] / 8, got_pairs[k] % 8, exp_order[k] / 8, exp_order[k] % 8);
      end
    end
    checks++;
    if (done_pulses != 1 || busy_errs != 0 || got_swaps.size() != 0) begin
      failures++;
      $display("FAIL order_done: got done %0d busy_err %0d swaps %0d expected 1 0 0",
               done_pulses, busy_errs, got_swaps.size());
    end
    checks++;
    if (sweep_s !== (Stats ? 8'd1 : 8'd0) || swapc_s !== 16'd0) begin
      failures++;
      $display("FAIL order_counters: got sweep %0d swap %0d expected %0d 0",
               sweep_s, swapc_s, Stats ? 1 : 0);
    end
  endtask

  task automatic test_first_improvement;
    drive_small(1, 1'b1);
    checks++;
    if (timed_out || got_pairs.size() != 12) begin
      failures++;
      $display("FAIL improve_pairs: got %0d pairs (timeout %0d) expected 12",
               got_pairs.size(), timed_out);
    end
    checks++;
    if (got_swaps.size() != 1 || (got_swaps.size() == 1 && got_swaps[0] != 20)) begin
      failures++;
      $display("FAIL improve_swap: got %0d swaps first code %0d expected 1 swap (2,4)",
               got_swaps.size(), got_swaps.size() > 0 ? got_swaps[0] : -1);
    end
    checks++;
    if (stable_errs != 0 || overlap_errs != 0) begin
      failures++;
      $display("FAIL improve_handshake: got unstable %0d overlap %0d expected 0 0",
               stable_errs, overlap_errs);
    end
    checks++;
    if (sweep_s !== (Stats ? 8'd2 : 8'd0) || swapc_s !== (Stats ? 16'd1 : 16'd0)) begin
      failures++;
      $display("FAIL improve_counters: got sweep %0d swap %0d expected %0d %0d",
               sweep_s, swapc_s, Stats ? 2 : 0, Stats ? 1 : 0);
    end
    @(negedge clk);
    checks++;
    if (done_s !== 1'b0) begin
      failures++;
      $display("FAIL done_pulse_width: got done %b expected 0", done_s);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (sweep_s !== (Stats ? 8'd2 : 8'd0) || swapc_s !== (Stats ? 16'd1 : 16'd0) || busy_s) begin
      failures++;
      $display("FAIL counters_hold: got sweep %0d swap %0d busy %b", sweep_s, swapc_s, busy_s);
    end
  endtask

  task automatic test_back_to_back;
    drive_small(0, 1'b0);
    checks++;
    if (start_wait != 1 || timed_out) begin
      failures++;
      $display("FAIL idle_start_latency: got %0d cycles expected 1", start_wait);
    end
    drive_small(0, 1'b0);
    checks++;
    if (start_wait != 2) begin
      failures++;
      $display("FAIL b2b_start_latency: got %0d cycles expected 2", start_wait);
    end
    checks++;
    if (timed_out || got_pairs.size() != 6 || (got_pairs.size() > 0 && got_pairs[0] != 10)) begin
      failures++;
      $display("FAIL b2b_run: got %0d pairs (timeout %0d) expected 6 from (1,2)",
               got_pairs.size(), timed_out);
    end
  endtask

  task automatic test_sweep_cap;
    int ncand, nswap, pend;
    bit finished;
    ncand = 0; nswap = 0; pend = 0; finished = 1'b0;
    bus_b.cand_ready = 1'b1;
    bus_b.swap_ready = 1'b1;
    start_b = 1'b1;
    @(negedge clk);
    start_b = 1'b0;
    checks++;
    if (bus_b.cand_valid !== 1'b1 || {bus_b.cand_i, bus_b.cand_j} !== {6'd1, 6'd2}) begin
      failures++;
      $display("FAIL cap_first_pair: got cv %b (%0d,%0d) expected 1 (1,2)",
               bus_b.cand_valid, bus_b.cand_i, bus_b.cand_j);
    end
    for (int cyc = 0; cyc < 30000; cyc++) begin
      bus_b.res_valid = (pend != 0);
      bus_b.res_delta = -1;
      pend = 0;
      if (bus_b.cand_valid) begin
        ncand++;
        pend = 1;
      end
      if (bus_b.swap_valid) nswap++;
      if (done_b) begin
        finished = 1'b1;
        break;
      end
      @(negedge clk);
    end
    bus_b.res_valid = 1'b0;
    bus_b.cand_ready = 1'b0;
    bus_b.swap_ready = 1'b0;
    checks++;
    if (!finished || ncand != BigPairs || nswap != BigPairs) begin
      failures++;
      $display("FAIL cap_run: got done %0d cands %0d swaps %0d expected 1 %0d %0d",
               finished, ncand, nswap, BigPairs, BigPairs);
    end
    checks++;
    if (sweep_b !== (Stats ? 8'(BigSweeps) : 8'd0) ||
        swapc_b !== (Stats ? 16'(BigPairs) : 16'd0)) begin
      failures++;
      $display("FAIL cap_counters: got sweep %0d swap %0d expected %0d %0d", sweep_b, swapc_b,
               Stats ? BigSweeps : 0, Stats ? BigPairs : 0);
    end
  endtask

  initial begin
    bus_s.cand_ready = 1'b0; bus_s.swap_ready = 1'b0;
    bus_s.res_valid  = 1'b0; bus_s.res_delta  = '0;
    bus_b.cand_ready = 1'b0; bus_b.swap_ready = 1'b0;
    bus_b.res_valid  = 1'b0; bus_b.res_delta  = '0;
    test_reset();
    test_unsolicited();
    test_reset_mid_run();
    test_sweep_order();
    test_first_improvement();
    test_back_to_back();
    test_sweep_cap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/tsp_2opt_sched.md
# tsp_2opt_sched

Sequencer that drives the TSP tour-improvement datapath through 2-opt sweeps over the 64-city path. On `start` it issues every candidate edge pair (i, j) to the distance-delta evaluator, one at a time. It commits each improving move as a segment-reversal request to the path store, and repeats sweeps until a sweep yields no improvement or the sweep cap is reached. It sits between the top-level control and the `tsp` path/coordinate storage.

## Interface
- `N`, 64, number of cities; path[0] is fixed, N >= 4
- `IDX_W`, 6, city index width, $clog2(N)
- `DELTA_W`, 32, width of signed tour-length delta
- `MAX_SWEEPS`, 16, maximum sweeps per run, >= 1
- `clk` in 1 — single clock, all logic on posedge
- `rst_n` in 1 — asynchronous, active-low reset
- `start` in 1 — run request, sampled in IDLE only
- `busy` out 1 — high from the cycle after `start` is accepted until `done`
- `done` out 1 — one-cycle pulse at end of run
- `cand_valid` out 1 — candidate pair valid
- `cand_ready` in 1 — evaluator accepts the candidate
- `cand_i`, `cand_j` out IDX_W — candidate pair, with 1 <= i < j <= N-1
- `res_valid` in 1 — evaluator result valid, one-cycle pulse
- `res_delta` in DELTA_W — signed (new − old) length for the last accepted pair
- `swap_valid` out 1 — reversal request valid
- `swap_ready` in 1 — path store accepts the reversal
- `swap_i`, `swap_j` out IDX_W — reverse path[i..j], inclusive
- `sweep_count` out 8 — completed sweeps in the current or last run
- `swap_count` out 16 — committed swaps in the current or last run

## Operation
- States: IDLE, ISSUE, WAIT, SWAP, DONE.
- **IDLE**
  - `start`=1 → clear the counters and the sweep-improved flag, set (i, j) = (1, 2), go to ISSUE.
  - `start` in any other state is ignored.
- **ISSUE**
  - Drive `cand_valid`=1 with `cand_i`/`cand_j` held stable.
  - On `cand_valid && cand_ready` → WAIT.
- **WAIT**
  - On `res_valid`: if `res_delta` < 0 (signed), latch the pair and go to SWAP. Otherwise advance.
  - `res_valid` outside WAIT is ignored.
- **SWAP**
  - Drive `swap_valid` with the latched pair.
  - On handshake: `swap_count`++ (saturating at 0xFFFF), set the improved flag, then advance.
- **Advance**
  - j++. If j > N-1, then i++ and j = i+1.
  - If i > N-2, the sweep has ended: `sweep_count`++ (saturating at 255).
    - If the improved flag was clear, or `sweep_count` now equals `MAX_SWEEPS` → DONE.
    - Otherwise clear the flag, set (i, j) = (1, 2), go to ISSUE.
- **DONE**
  - Pulse `done` for one cycle, drop `busy`, return to IDLE.
- Policy is first-improvement: a swap is committed before the next pair is issued. The path seen by later pairs is the updated one.
- Pairs per sweep = (N-2)(N-1)/2; 1953 for N=64.

## Timing
- Reset values: `busy`=0, `done`=0, `cand_valid`=0, `swap_valid`=0, `cand_i`=`cand_j`=`swap_i`=`swap_j`=0, `sweep_count`=0, `swap_count`=0, state IDLE.
- `start` accepted at edge T: `busy`=1 and `cand_valid`=1 from T+1.
- At most one candidate is outstanding. `cand_valid` is never high during WAIT or SWAP.
- `res_valid` may arrive at the earliest one cycle after the candidate handshake cycle.
- After a non-improving result at edge T, the next `cand_valid` is high from T+1.
- After an improving result at edge T, `swap_valid` is high from T+1. After the swap handshake at edge S, the next `cand_valid` is high from S+1.
- Final result or swap handshake at edge T:
  - `done`=1 during cycle T+1.
  - `busy`=0 from T+1, in the same cycle as `done`.
  - A new `start` is accepted from T+2.
- `swap_valid` and `cand_valid` are never high together.
- Reset mid-run returns the block to IDLE immediately and drops all valids. Any in-flight evaluator result is discarded.
- Counters hold their final values after DONE until the next accepted `start`.

## Configuration
- `TSP_SCHED_STATS_EN`
  - Defined: `sweep_count` and `swap_count` are implemented as specified.
  - Undefined: both outputs are tied to 0. Sweep termination uses an internal sweep counter only, so the MAX_SWEEPS cap behaviour is unchanged.

## Test plan
- Reset with `start` high and `rst_n`=0 → all outputs 0. Release `rst_n` with `start` still high → `busy`=1 and `cand_valid`=1 with (1,2) on the next cycle.
- N=5, evaluator always ready, `res_delta`=0 one cycle after each handshake:
  - pair order is exactly (1,2),(1,3),(1,4),(2,3),(2,4),(3,4);
  - `done` pulses once; `sweep_count`=1, `swap_count`=0.
- N=64, `res_delta`=−1 for all pairs, `swap_ready`=1 → DONE after 16 sweeps; `sweep_count`=16, `swap_count`=31248.
- N=5, `res_delta`=−5 only for the first-sweep pair (2,4), else +3; `cand_ready`/`swap_ready` randomly stalled:
  - exactly one `swap_valid` with (2,4), and its pair stays stable during the stall;
  - a second sweep with no swaps, then `done`; `sweep_count`=2, `swap_count`=1.
- Unsolicited `res_valid` in ISSUE and `start` pulses while `busy` → no state change, no extra candidates.
- `rst_n` pulsed low while in WAIT → IDLE, valids 0, counters 0. A new `start` begins again at (1,2).
